// File: rtl/fifo_flush_pack_pkg.sv
// Shared types and helpers for the flushable packing FIFO.
// The FSM encoding keeps the legacy state numbering so existing debug captures still decode.
package fifo_flush_pack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } flush_state_e;

   function automatic int unsigned ptr_w(int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned cnt_w(int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_flush_pack_if.sv
// Write, flush, packed-read and status signals of the flushable packing FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_flush_pack_if #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 32,
   parameter int PACK   = 8
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                     fifo_wr_valid_i;
   logic                     fifo_wr_ready_o;
   logic [DATA_W-1:0]        fifo_wr_data_i;
   logic                     fifo_flush_i;
   logic                     fifo_rd_valid_o;
   logic                     fifo_rd_ready_i;
   logic [PACK*DATA_W-1:0]   fifo_rd_data_o;
   logic [PACK-1:0]          fifo_rd_lanes_o;
   logic                     fifo_flush_busy_o;
   logic                     fifo_flush_done_o;
   logic                     fifo_empty_o;
   logic                     fifo_full_o;
   logic [CNT_W-1:0]         fifo_count_o;
   logic                     fifo_overflow_o;

   modport master (
      output fifo_wr_valid_i, fifo_wr_data_i, fifo_flush_i, fifo_rd_ready_i,
      input  fifo_wr_ready_o, fifo_rd_valid_o, fifo_rd_data_o, fifo_rd_lanes_o,
             fifo_flush_busy_o, fifo_flush_done_o, fifo_empty_o, fifo_full_o,
             fifo_count_o, fifo_overflow_o
   );

   modport slave (
      input  fifo_wr_valid_i, fifo_wr_data_i, fifo_flush_i, fifo_rd_ready_i,
      output fifo_wr_ready_o, fifo_rd_valid_o, fifo_rd_data_o, fifo_rd_lanes_o,
             fifo_flush_busy_o, fifo_flush_done_o, fifo_empty_o, fifo_full_o,
             fifo_count_o, fifo_overflow_o
   );
endinterface

// File: rtl/fifo_flush_pack_mem.sv
// DEPTH x DATA_W storage with one write port and PACK combinational read taps
// starting at rd_ptr_i (wrapping modulo DEPTH).
module fifo_flush_mem import fifo_flush_pack_pkg::*; #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 32,
   parameter int PACK   = 8
) (
   input  logic                          clk,
   input  logic                          we_i,
   input  logic [$clog2(DEPTH)-1:0]      wr_ptr_i,
   input  logic [DATA_W-1:0]             wr_data_i,
   input  logic [$clog2(DEPTH)-1:0]      rd_ptr_i,
   output logic [PACK-1:0][DATA_W-1:0]   taps_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[wr_ptr_i] <= wr_data_i;
   end

   always_comb begin
      for (int unsigned k = 0; k < PACK; k++) begin
         taps_o[k] = mem_q[rd_ptr_i + PTR_W'(k)];
      end
   end
endmodule

// File: rtl/fifo_flush_pack.sv
// Flushable FIFO: stores DATA_W-bit entries and, on flush, drains the entries present
// at flush start as PACK-wide beats (padded final beat with a lane mask).
module fifo_flush_pack import fifo_flush_pack_pkg::*; #(
   parameter int                DATA_W  = 4,
   parameter int                DEPTH   = 32,
   parameter int                PACK    = 8,
   parameter logic [DATA_W-1:0] PAD_VAL = 4'hC
) (
   input  logic            clk,
   input  logic            reset,
   fifo_flush_pack_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   flush_state_e             state_q, state_d;
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d, rem_q, rem_d;
   logic                     rd_valid_q, rd_valid_d, overflow_q, overflow_d;
   logic [PACK*DATA_W-1:0]   rd_data_q, rd_data_d;
   logic [PACK-1:0]          rd_lanes_q, rd_lanes_d;
   logic [PACK-1:0][DATA_W-1:0] taps;
   logic                     full, push, accept, load;
   logic [CNT_W-1:0]         src, n;

   assign full   = (count_q == CNT_W'(DEPTH));
   assign push   = bus.fifo_wr_valid_i & ~full;
   assign accept = rd_valid_q & bus.fifo_rd_ready_i;

   fifo_flush_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PACK(PACK)) u_mem (
      .clk       (clk),
      .we_i      (push),
      .wr_ptr_i  (wr_ptr_q),
      .wr_data_i (bus.fifo_wr_data_i),
      .rd_ptr_i  (rd_ptr_q),
      .taps_o    (taps)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (bus.fifo_flush_i) state_d = (count_q == '0) ? ST_DONE : ST_DRAIN;
         ST_DRAIN: if (accept && rem_q == '0) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.fifo_flush_busy_o = (state_q != ST_IDLE);
      bus.fifo_flush_done_o = (state_q == ST_DONE);
   end

   // The flush snapshot is taken from count in IDLE and then tracked in rem;
   // entries leave storage at the load edge, not at the accept edge.
   always_comb begin
      load = ((state_q == ST_IDLE) && bus.fifo_flush_i && count_q != '0) ||
             ((state_q == ST_DRAIN) && accept && rem_q != '0);
      src  = (state_q == ST_IDLE) ? count_q : rem_q;
      n    = (src > CNT_W'(PACK)) ? CNT_W'(PACK) : src;

      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rem_d      = rem_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      rd_lanes_d = rd_lanes_q;
      overflow_d = overflow_q | (bus.fifo_wr_valid_i & full);
      count_d    = count_q + CNT_W'(push) - (load ? n : '0);

      if (load) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(n);
         rem_d      = src - n;
         rd_valid_d = 1'b1;
         for (int unsigned k = 0; k < PACK; k++) begin
            rd_lanes_d[k]                   = (CNT_W'(k) < n);
            rd_data_d[k*DATA_W +: DATA_W]   = (CNT_W'(k) < n) ? taps[k] : PAD_VAL;
         end
      end else if (accept) begin
         rd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rem_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_lanes_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rem_q      <= rem_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_lanes_q <= rd_lanes_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.fifo_wr_ready_o = ~full;
   assign bus.fifo_rd_valid_o = rd_valid_q;
   assign bus.fifo_rd_data_o  = rd_data_q;
   assign bus.fifo_rd_lanes_o = rd_lanes_q;
   assign bus.fifo_empty_o    = (count_q == '0);
   assign bus.fifo_full_o     = full;
   assign bus.fifo_count_o    = count_q;
   assign bus.fifo_overflow_o = overflow_q;
endmodule

// File: tb/tb_fifo_flush_pack.sv
// Bench for fifo_flush_pack: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized soak.
module tb_fifo_flush_pack;
   localparam int                DATA_W = 4;
   localparam int                DEPTH  = 32;
   localparam int                PACK   = 8;
   localparam logic [DATA_W-1:0] PAD    = 4'hC;
   localparam int                BW     = PACK*DATA_W;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fifo_flush_pack_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PACK(PACK)) bus ();

   fifo_flush_pack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PACK(PACK), .PAD_VAL(PAD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   // reference model: queue of stored entries plus the beat currently presented
   logic [DATA_W-1:0] mq[$];
   bit                m_busy, m_done, m_valid, m_ovf;
   int unsigned       m_rem;
   logic [BW-1:0]     m_data;
   logic [PACK-1:0]   m_lanes;

   logic [BW-1:0]     cap_data[$];
   logic [PACK-1:0]   cap_lanes[$];
   int unsigned       done_seen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy = 0; m_done = 0; m_valid = 0; m_ovf = 0; m_rem = 0;
      m_data = '0; m_lanes = '0;
   endtask

   task automatic model_step();
      bit acc, ld, wr_acc;
      int unsigned n;
      acc    = m_valid && bus.fifo_rd_ready_i;
      ld     = 0;
      wr_acc = bus.fifo_wr_valid_i && (mq.size() < DEPTH);
      if (bus.fifo_wr_valid_i && !wr_acc) m_ovf = 1;
      if (m_done) begin
         m_done = 0; m_busy = 0;
      end else if (!m_busy) begin
         if (bus.fifo_flush_i) begin
            m_busy = 1;
            m_rem  = mq.size();
            if (m_rem == 0) m_done = 1;
            else            ld = 1;
         end
      end else if (acc) begin
         if (m_rem > 0) ld = 1;
         else begin
            m_valid = 0; m_done = 1;
         end
      end
      if (ld) begin
         n = (m_rem < PACK) ? m_rem : PACK;
         for (int k = 0; k < PACK; k++) begin
            if (k < n) begin
               m_data[k*DATA_W +: DATA_W] = mq.pop_front();
               m_lanes[k] = 1'b1;
            end else begin
               m_data[k*DATA_W +: DATA_W] = PAD;
               m_lanes[k] = 1'b0;
            end
         end
         m_rem  -= n;
         m_valid = 1;
      end
      if (wr_acc) mq.push_back(bus.fifo_wr_data_i);
   endtask

   task automatic compare_all();
      chk("count",    64'(bus.fifo_count_o),    64'(mq.size()));
      chk("empty",    64'(bus.fifo_empty_o),    64'(mq.size() == 0));
      chk("full",     64'(bus.fifo_full_o),     64'(mq.size() == DEPTH));
      chk("wr_ready", 64'(bus.fifo_wr_ready_o), 64'(mq.size() != DEPTH));
      chk("rd_valid", 64'(bus.fifo_rd_valid_o), 64'(m_valid));
      chk("busy",     64'(bus.fifo_flush_busy_o), 64'(m_busy));
      chk("done",     64'(bus.fifo_flush_done_o), 64'(m_done));
      chk("overflow", 64'(bus.fifo_overflow_o), 64'(m_ovf));
      if (m_valid) begin
         chk("rd_data",  64'(bus.fifo_rd_data_o),  64'(m_data));
         chk("rd_lanes", 64'(bus.fifo_rd_lanes_o), 64'(m_lanes));
      end
   endtask

   // one clock: compare at negedge, advance model at posedge, return 1 unit after the edge
   task automatic cyc();
      @(negedge clk);
      if (reset) begin
         compare_all();
         if (bus.fifo_rd_valid_o && bus.fifo_rd_ready_i) begin
            cap_data.push_back(bus.fifo_rd_data_o);
            cap_lanes.push_back(bus.fifo_rd_lanes_o);
         end
         if (bus.fifo_flush_done_o) done_seen++;
      end
      @(posedge clk);
      if (!reset) model_reset();
      else        model_step();
      #1;
   endtask

   task automatic drive(input logic wv, input logic [DATA_W-1:0] wd, input logic fl, input logic rr);
      bus.fifo_wr_valid_i = wv;
      bus.fifo_wr_data_i  = wd;
      bus.fifo_flush_i    = fl;
      bus.fifo_rd_ready_i = rr;
   endtask

   task automatic wait_idle(input int unsigned max_cyc);
      int unsigned i;
      i = 0;
      while ((bus.fifo_flush_busy_o || m_busy) && i < max_cyc) begin
         cyc();
         i++;
      end
      if (i >= max_cyc) chk("flush_timeout", 64'(i), 64'(0));
   endtask

   task automatic clear_cap();
      cap_data.delete();
      cap_lanes.delete();
      done_seen = 0;
   endtask

   int unsigned lanes_total;

   initial begin
      drive(0, '0, 0, 0);
      reset = 1'b1;
      model_reset();
      #2 reset = 1'b0;
      repeat (3) cyc();
      chk("rst_count", 64'(bus.fifo_count_o), 64'(0));
      chk("rst_empty", 64'(bus.fifo_empty_o), 64'(1));
      chk("rst_data",  64'(bus.fifo_rd_data_o), 64'(0));
      chk("rst_wrrdy", 64'(bus.fifo_wr_ready_o), 64'(1));
      reset = 1'b1;
      cyc();

      // 1: ten entries 1..A, flush with consumer always ready
      for (int i = 1; i <= 10; i++) begin
         drive(1, DATA_W'(i), 0, 1);
         cyc();
      end
      clear_cap();
      drive(0, '0, 1, 1);
      cyc();
      drive(0, '0, 0, 1);
      wait_idle(50);
      cyc();
      chk("t1_beats", 64'(cap_data.size()), 64'(2));
      if (cap_data.size() >= 2) begin
         chk("t1_beat0",  64'(cap_data[0]),  64'h87654321);
         chk("t1_lanes0", 64'(cap_lanes[0]), 64'hFF);
         chk("t1_beat1",  64'(cap_data[1]),  64'hCCCCCCA9);
         chk("t1_lanes1", 64'(cap_lanes[1]), 64'h03);
      end
      chk("t1_done", 64'(done_seen), 64'(1));
      chk("t1_empty", 64'(bus.fifo_empty_o), 64'(1));

      // 2: flush on empty FIFO
      drive(0, '0, 1, 1);
      cyc();
      drive(0, '0, 0, 1);
      chk("t2_done_hi", 64'(bus.fifo_flush_done_o), 64'(1));
      chk("t2_busy_hi", 64'(bus.fifo_flush_busy_o), 64'(1));
      chk("t2_novalid", 64'(bus.fifo_rd_valid_o), 64'(0));
      cyc();
      chk("t2_done_lo", 64'(bus.fifo_flush_done_o), 64'(0));
      chk("t2_busy_lo", 64'(bus.fifo_flush_busy_o), 64'(0));

      // 3: fill, overflow, stalled drain
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, DATA_W'($urandom), 0, 0);
         cyc();
      end
      chk("t3_full", 64'(bus.fifo_full_o), 64'(1));
      chk("t3_wrrdy", 64'(bus.fifo_wr_ready_o), 64'(0));
      drive(1, DATA_W'($urandom), 0, 0);
      cyc();
      chk("t3_ovf", 64'(bus.fifo_overflow_o), 64'(1));
      chk("t3_count", 64'(bus.fifo_count_o), 64'(32));
      clear_cap();
      for (int i = 0; i < 100; i++) begin
         drive(0, '0, (i == 0), (i % 4 == 3));
         cyc();
         if (i > 2 && !bus.fifo_flush_busy_o && !m_busy) break;
      end
      chk("t3_beats", 64'(cap_data.size()), 64'(4));
      chk("t3_idle", 64'(bus.fifo_flush_busy_o), 64'(0));

      // 4: 28 entries, flush, 12 more written during the drain, then a wrapping second flush
      for (int i = 0; i < 28; i++) begin
         drive(1, DATA_W'($urandom), 0, 0);
         cyc();
      end
      clear_cap();
      drive(0, '0, 1, 0);
      cyc();
      for (int i = 0; i < 12; i++) begin
         drive(1, DATA_W'($urandom), 0, ($urandom_range(0, 9) < 7));
         cyc();
      end
      drive(0, '0, 0, 1);
      wait_idle(80);
      lanes_total = 0;
      foreach (cap_lanes[i]) lanes_total += $countones(cap_lanes[i]);
      chk("t4_beats", 64'(cap_data.size()), 64'(4));
      chk("t4_lanes", 64'(lanes_total), 64'(28));
      if (cap_lanes.size() == 4) chk("t4_last", 64'(cap_lanes[3]), 64'h0F);
      chk("t4_left", 64'(bus.fifo_count_o), 64'(12));
      clear_cap();
      drive(0, '0, 1, 1);
      cyc();
      drive(0, '0, 0, 1);
      wait_idle(50);
      lanes_total = 0;
      foreach (cap_lanes[i]) lanes_total += $countones(cap_lanes[i]);
      chk("t4b_lanes", 64'(lanes_total), 64'(12));

      // 5: write coincides with the first beat load
      cyc();
      for (int i = 0; i < 9; i++) begin
         drive(1, DATA_W'(i), 0, 0);
         cyc();
      end
      drive(1, 4'hE, 1, 0);
      cyc();
      drive(0, '0, 0, 1);
      chk("t5_count", 64'(bus.fifo_count_o), 64'(2));
      wait_idle(50);

      // randomized soak
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 1) == 1), DATA_W'($urandom), ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 9) < 7));
         cyc();
      end
      drive(0, '0, 0, 1);
      wait_idle(100);

      // 6: reset in the middle of a drain
      for (int i = 0; i < 12; i++) begin
         drive(1, DATA_W'($urandom), 0, 0);
         cyc();
      end
      drive(0, '0, 1, 0);
      cyc();
      drive(0, '0, 0, 0);
      repeat (2) cyc();
      chk("t6_pre_busy", 64'(bus.fifo_flush_busy_o), 64'(1));
      reset = 1'b0;
      #1;
      chk("t6_valid", 64'(bus.fifo_rd_valid_o), 64'(0));
      chk("t6_data",  64'(bus.fifo_rd_data_o), 64'(0));
      chk("t6_lanes", 64'(bus.fifo_rd_lanes_o), 64'(0));
      chk("t6_busy",  64'(bus.fifo_flush_busy_o), 64'(0));
      chk("t6_done",  64'(bus.fifo_flush_done_o), 64'(0));
      chk("t6_count", 64'(bus.fifo_count_o), 64'(0));
      chk("t6_ovf",   64'(bus.fifo_overflow_o), 64'(0));
      model_reset();
      repeat (2) cyc();
      reset = 1'b1;
      clear_cap();
      repeat (4) cyc();
      chk("t6_nodone", 64'(done_seen), 64'(0));
      chk("t6_empty", 64'(bus.fifo_empty_o), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
